// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Integer register file for the RockWave core with a scoreboard for
//   hazard detection. x1..x31 hold XLEN-bit values; x0 reads as zero and
//   ignores writes. Decode/issue reads two sources and reserves a
//   destination; write-back retires results and releases the reservation.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> write-back data is forwarded to the read ports in the
//                  write cycle, and source hazards are relieved by it.
//     undefined -> reads return storage only; a dependent instruction
//                  stalls through the write-back cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rs1_addr/rs2_addr          source indices
//   rs1_data/rs2_data          combinational read data
//   issue_valid/issue_wr/issue_rd  instruction presented, writes rd, rd index
//   issue_stall                combinational hold request toward issue
//   wb_valid/wb_rd/wb_data     write-back result
//   flush                      synchronous clear of all reservations
//   busy                       scoreboard vector, bit 0 always 0

module reg_file_sb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [31:0]     busy
);

  // Entry 0 is reset and never written, so it always holds zero.
  logic [XLEN-1:0] regs [32];
  logic [31:0]     busy_q;
  logic [31:0]     busy_nxt;
  logic            fwd1;
  logic            fwd2;
  logic            src_hz1;
  logic            src_hz2;
  logic            waw;
  logic            rsv;
  logic            wb_wr;

  assign wb_wr = wb_valid && (wb_rd != 5'd0);

`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by rst_n so the read ports stay 0 while in reset.
  assign fwd1 = rst_n && wb_valid && (wb_rd == rs1_addr) && (rs1_addr != 5'd0);
  assign fwd2 = rst_n && wb_valid && (wb_rd == rs2_addr) && (rs2_addr != 5'd0);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : (fwd1 ? wb_data : regs[rs1_addr]);
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : (fwd2 ? wb_data : regs[rs2_addr]);

  assign src_hz1     = busy_q[rs1_addr] & ~fwd1;
  assign src_hz2     = busy_q[rs2_addr] & ~fwd2;
  // A pending write to rd is never relieved by forwarding.
  assign waw         = issue_wr & busy_q[issue_rd];
  assign issue_stall = issue_valid & (src_hz1 | src_hz2 | waw);

  assign rsv  = issue_valid & issue_wr & ~issue_stall & (issue_rd != 5'd0);
  assign busy = busy_q;

  // Release first, then reserve, so a coincident set on the same index wins.
  always_comb begin
    busy_nxt = busy_q;
    if (wb_wr) busy_nxt[wb_rd] = 1'b0;
    if (rsv)   busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  // Storage writes are independent of flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_wr) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        issue_valid, issue_wr;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_wr = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
    rs1_addr = 0; rs2_addr = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #3;
    chk("reset_busy", busy, 32'h0);
    chk("reset_stall", {31'b0, issue_stall}, 32'h0);
    chk("reset_rs1", rs1_data, 32'h0);
    step();
    rst_n = 1;

    // Every index reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      rs1_addr = i[4:0];
      rs2_addr = 5'(31 - i);
      #1;
      chk("read_all_rs1", rs1_data, 32'h0);
      chk("read_all_rs2", rs2_data, 32'h0);
    end
    chk("read_all_busy", busy, 32'h0);

    // Write to x0 is discarded.
    idle_inputs();
    wb_valid = 1; wb_rd = 0; wb_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    #2;
    chk("x0_read", rs1_data, 32'h0);
    chk("x0_busy", busy, 32'h0);
    step();

    // RAW: reserve x5, then a reader of x5 stalls until write-back.
    issue_valid = 1; issue_wr = 1; issue_rd = 5;
    #2;
    chk("rsv5_stall", {31'b0, issue_stall}, 32'h0);
    step();
    issue_wr = 0; issue_rd = 0; rs1_addr = 5;
    #2;
    chk("raw_busy", busy, 32'h0000_0020);
    chk("raw_stall", {31'b0, issue_stall}, 32'h1);
    step();
    wb_valid = 1; wb_rd = 5; wb_data = 32'h1234;
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("raw_wb_stall", {31'b0, issue_stall}, 32'h0);
    chk("raw_wb_data", rs1_data, 32'h1234);
`else
    chk("raw_wb_stall", {31'b0, issue_stall}, 32'h1);
    chk("raw_wb_data", rs1_data, 32'h0);
`endif
    step();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    #2;
    chk("raw_after_stall", {31'b0, issue_stall}, 32'h0);
    chk("raw_after_data", rs1_data, 32'h1234);
    chk("raw_after_busy", busy, 32'h0);
    step();

    // WAW: x7 busy, issue rd=7 while write-back of x7 arrives.
    idle_inputs();
    issue_valid = 1; issue_wr = 1; issue_rd = 7;
    step();
    wb_valid = 1; wb_rd = 7; wb_data = 32'h77;
    #2;
    chk("waw_stall", {31'b0, issue_stall}, 32'h1);
    chk("waw_busy", busy, 32'h0000_0080);
    step();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    #2;
    chk("waw_retry_stall", {31'b0, issue_stall}, 32'h0);
    step();
    issue_valid = 0; issue_wr = 0; issue_rd = 0; rs1_addr = 7;
    #2;
    chk("waw_retry_busy", busy, 32'h0000_0080);
    chk("waw_x7", rs1_data, 32'h77);
    step();

    // Set wins: reserve x3, release it, then reserve x3 with a coincident wb x3.
    idle_inputs();
    issue_valid = 1; issue_wr = 1; issue_rd = 3;
    step();
    idle_inputs();
    wb_valid = 1; wb_rd = 3; wb_data = 32'h30;
    step();
    issue_valid = 1; issue_wr = 1; issue_rd = 3;
    wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
    #2;
    chk("setwin_stall", {31'b0, issue_stall}, 32'h0);
    step();
    idle_inputs();
    rs1_addr = 3;
    #2;
    chk("setwin_busy", busy, 32'h0000_0088);
    chk("setwin_x3", rs1_data, 32'h33);
    step();

    // Flush: reserve x1, x2, x31; flush drops everything incl. a same-cycle reservation.
    idle_inputs();
    issue_valid = 1; issue_wr = 1; issue_rd = 1;
    step();
    issue_rd = 2;
    step();
    issue_rd = 31;
    step();
    issue_rd = 9;
    #2;
    chk("pre_flush_busy", busy, 32'h8000_008E);
    chk("pre_flush_stall", {31'b0, issue_stall}, 32'h0);
    flush = 1;
    step();
    idle_inputs();
    #2;
    chk("flush_busy", busy, 32'h0);
    wb_valid = 1; wb_rd = 2; wb_data = 32'h55;
    step();
    idle_inputs();
    rs1_addr = 2;
    #2;
    chk("post_flush_x2", rs1_data, 32'h55);
    chk("post_flush_busy", busy, 32'h0);
    step();

    // Asynchronous reset mid-cycle.
    idle_inputs();
    wb_valid = 1; wb_rd = 4; wb_data = 32'hFF;
    issue_valid = 1; issue_wr = 1; issue_rd = 10;
    step();
    idle_inputs();
    rs1_addr = 4; issue_valid = 1; issue_wr = 1; issue_rd = 10;
    #2;
    chk("pre_rst_busy", busy, 32'h0000_0400);
    chk("pre_rst_stall", {31'b0, issue_stall}, 32'h1);
    chk("pre_rst_x4", rs1_data, 32'hFF);
    rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 32'h0);
    chk("async_rst_stall", {31'b0, issue_stall}, 32'h0);
    chk("async_rst_x4", rs1_data, 32'h0);
    step();
    idle_inputs();
    rst_n = 1;
    #2;
    chk("after_rst_busy", busy, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Integer register file for the RockWave core, with scoreboard-based hazard detection. Holds x1–x31 as XLEN-bit registers and hard-wires x0 to zero. Sits between decode/issue, which reads two sources and reserves a destination, and write-back, which retires results into the storage and releases the reservation. Drives a combinational stall toward issue while a source or destination register has a write pending.

## Interface
- XLEN, 32, register width, from core_general.vh
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rs1_addr  input  5  source 1 index
- rs2_addr  input  5  source 2 index
- rs1_data  output  XLEN  source 1 read data, combinational
- rs2_data  output  XLEN  source 2 read data, combinational
- issue_valid  input  1  decode presents an instruction this cycle
- issue_wr  input  1  the instruction writes a destination
- issue_rd  input  5  destination index
- issue_stall  output  1  instruction must be held, combinational
- wb_valid  input  1  write-back result valid
- wb_rd  input  5  write-back destination
- wb_data  input  XLEN  write-back value
- flush  input  1  synchronous pipeline flush, clears all reservations
- busy  output  32  scoreboard vector, bit 0 always 0

## Operation
- Storage: x1–x31 each reset to 0. Entry n loads wb_data on a clock edge when wb_valid=1 and wb_rd=n. A write to x0 is discarded.
- Reads: rsX_data = 0 when rsX_addr=0, otherwise the stored value.
- Scoreboard: busy[31:1] flops, reset to 0. busy[0] is tied to 0.
- Hazard terms:
  - src_hz(X) = busy[rsX_addr] & ~fwd(X).
  - fwd(X) = 0 without the bypass. With the bypass it is wb_valid & wb_rd==rsX_addr & rsX_addr!=0.
  - waw = issue_wr & busy[issue_rd]. No bypass relief applies to waw.
- Stall: issue_stall = issue_valid & (src_hz(1) | src_hz(2) | waw).
  - Source checks apply regardless of whether the instruction uses rs2. Decode zeroes unused addresses.
- Reservation: on an edge where issue_valid & issue_wr & ~issue_stall & issue_rd!=0, set busy[issue_rd].
- Release: on an edge where wb_valid & wb_rd!=0, clear busy[wb_rd].
- Simultaneous set and clear of the same index: set wins and the bit stays 1, because a new producer is outstanding.
- Flush: on an edge with flush=1, all busy bits go to 0 and any reservation requested that cycle is dropped. Storage writes in the same cycle still occur.
- Write-backs arriving after a flush still update storage. Clearing an already-clear bit is harmless.
- Reset mid-operation: storage and busy clear immediately and asynchronously. issue_stall therefore falls to 0 while reset is asserted.

## Timing
- Write latency: a value written at edge T is readable from storage in cycle T+1.
- With the bypass: the value is readable in the write cycle itself, combinationally from wb_data.
- Reservation is visible in busy and issue_stall from the cycle after the issuing edge.
- Release is visible from the cycle after the wb_valid edge. With the bypass, the dependent instruction issues in the write-back cycle itself.
- issue_stall is a pure combinational function of current inputs and busy. Decode holds issue_* stable while it is high.
- Every output is 0 in reset.

## Configuration
- REGFILE_BYPASS_EN defined: write-back-to-read forwarding is enabled.
  - rsX_data = wb_data when fwd(X).
  - src_hz(X) is masked by fwd(X).
- Not defined: no forwarding. Reads return storage only, and a dependent instruction stalls through the write-back cycle, issuing one cycle later.

## Test plan
- Reset, then read all 32 indices: every read returns 0 and busy=0. Write 0xDEADBEEF to x0, then read x0: returns 0.
- Issue rd=5. The next cycle, issue with rs1=5: issue_stall=1. Apply wb_valid, wb_rd=5, wb_data=0x1234:
  - bypass build: stall=0 and rs1_data=0x1234 that cycle.
  - non-bypass build: stall=1 that cycle, then 0 the next cycle with rs1_data=0x1234.
- With busy[7]=1, issue rd=7 while wb_rd=7: stall=1 (waw), busy[7] stays 1. Next cycle, issue rd=7 again with no write-back: reservation accepted, busy[7]=1.
- With busy[3]=1, issue rd=3 without stall, gated by a prior clear, coincident with wb_rd=3: busy[3]=1 afterwards (set wins).
- Reserve x1, x2 and x31, then assert flush: busy=0 the next cycle. A later wb_rd=2, wb_data=0x55 updates x2 to 0x55 with busy unchanged.
- Assert rst_n=0 asynchronously mid-cycle with busy non-zero and x4=0xFF: busy, issue_stall and rs1_data(x4) go to 0 before the next clock edge.
